// File: rtl/vga_disp_pkg.sv
// Shared definitions for the streaming VGA display engine: timing helpers,
// run-state encoding, per-pixel pipeline flags and colour expansion.
package vga_disp_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } run_state_t;

  // Flags that travel alongside a pixel from the timing position to the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic win;
    logic lost;
    logic last;
  } pix_flags_t;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  // MSB replication so that full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = pix[15:11];
    g6 = pix[10:5];
    b5 = pix[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with raw (polarity-free) sync,
// active-region and frame event indications at stage 0.
module vga_timing_gen
  import vga_disp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             hs_act,
  output logic             vs_act,
  output logic             active,
  output logic             frame_start,
  output logic             frame_end,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster counters; held at the origin whenever the engine is idle.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign hs_act      = run && (h_cnt >= HS_FIRST) && (h_cnt < HS_STOP);
  assign vs_act      = run && (v_cnt >= VS_FIRST) && (v_cnt < VS_STOP);
  assign active      = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign frame_end   = run && h_wrap && v_wrap;
  assign h_pos       = h_cnt;
  assign v_pos       = v_cnt;

endmodule

// File: rtl/vga_stream_disp.sv
// VGA display engine fed from a frame-buffer read FIFO. Stage 0 is the raster
// position; FIFO data returns RD_LAT clocks later and the pin register is
// stage RD_LAT+1, with all control flags delayed to match.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | counters parked at (0,0), no reads, pins at idle levels
// ST_RUN   | frames stream continuously while enable is high
// ST_DRAIN | enable dropped mid-frame; finish the frame, then go idle
module vga_stream_disp
  import vga_disp_pkg::*;
#(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int          PIX_FMT    = 0,
  parameter int          IN_W       = 16,
  parameter int          IMG_X      = 0,
  parameter int          IMG_Y      = 0,
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter int          RD_LAT     = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter logic [23:0] UNDER_RGB  = 24'hFF00FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr_err,
  output logic             rd_req,
  input  logic [IN_W-1:0]  rd_q,
  input  logic             rd_empty,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank,
  output logic             vga_sync,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic [CNT_W-1:0] pos_x,
  output logic [CNT_W-1:0] pos_y,
  output logic             frame_start,
  output logic             vga_done,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] WIN_X      = CNT_W'(IMG_X);
  localparam logic [CNT_W-1:0] WIN_Y      = CNT_W'(IMG_Y);
  localparam logic [CNT_W-1:0] WIN_W      = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] WIN_H      = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] WIN_X_LAST = CNT_W'(IMG_X + IMG_W - 1);
  localparam logic [CNT_W-1:0] WIN_Y_LAST = CNT_W'(IMG_Y + IMG_H - 1);

  run_state_t       state;
  run_state_t       state_nxt;
  logic             run;
  logic             hs_act;
  logic             vs_act;
  logic             active;
  logic             frame_end;
  logic [CNT_W-1:0] h_pos;
  logic [CNT_W-1:0] v_pos;
  logic [CNT_W-1:0] x_off;
  logic [CNT_W-1:0] y_off;
  logic             in_win;
  logic             lost;
  pix_flags_t       st0;
  pix_flags_t       pipe [RD_LAT];
  pix_flags_t       ps;
  logic [23:0]      pix_fmt;
  logic [23:0]      rgb;

  assign run = (state != ST_IDLE);

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .hs_act      (hs_act),
    .vs_act      (vs_act),
    .active      (active),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .h_pos       (h_pos),
    .v_pos       (v_pos)
  );

  // Run-state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Run-state transitions; a frame always completes once started, and a
  // re-enable seen at the frame wrap continues straight into the next frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (frame_end) state_nxt = enable ? ST_RUN : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Modular offsets: a position left of/above the window wraps to a large
  // value, so one unsigned compare per axis covers both window edges.
  assign x_off  = h_pos - WIN_X;
  assign y_off  = v_pos - WIN_Y;
  assign in_win = active && (x_off < WIN_W) && (y_off < WIN_H);
  assign rd_req = in_win && !rd_empty;
  assign lost   = in_win && rd_empty;

  always_comb begin
    st0        = '0;
    st0.hs     = hs_act;
    st0.vs     = vs_act;
    st0.active = active;
    st0.win    = in_win;
    st0.lost   = lost;
    st0.last   = active && (h_pos == WIN_X_LAST) && (v_pos == WIN_Y_LAST);
  end

  // Flag delay line covering the FIFO read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= st0;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ps = pipe[RD_LAT-1];

  generate
    if (PIX_FMT == 1) begin : g_rgb888
      assign pix_fmt = rd_q[23:0];
    end else begin : g_rgb565
      assign pix_fmt = rgb565_to_888(rd_q[15:0]);
    end
  endgenerate

  // Output stage: sync polarity, blanking and colour selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs    <= ~HS_POL;
      vga_vs    <= ~VS_POL;
      vga_blank <= 1'b0;
      vga_done  <= 1'b0;
      rgb       <= '0;
    end else begin
      vga_hs    <= ps.hs ? HS_POL : ~HS_POL;
      vga_vs    <= ps.vs ? VS_POL : ~VS_POL;
      vga_blank <= ps.active;
      vga_done  <= ps.last;
      if (!ps.active)   rgb <= '0;
      else if (!ps.win) rgb <= BORDER_RGB;
      else if (ps.lost) rgb <= UNDER_RGB;
      else              rgb <= pix_fmt;
    end
  end

  // Sticky underflow; a new loss in the same clock as clr_err keeps it set.
  always_ff @(posedge clk) begin
    if (rst)          underflow <= 1'b0;
    else if (lost)    underflow <= 1'b1;
    else if (clr_err) underflow <= 1'b0;
  end

  assign vga_r    = rgb[23:16];
  assign vga_g    = rgb[15:8];
  assign vga_b    = rgb[7:0];
  assign vga_sync = 1'b0;
  assign pos_x    = h_pos;
  assign pos_y    = v_pos;

endmodule

// File: tb/tb_vga_stream_disp.sv
// Directed bench for vga_stream_disp using a 14x7 raster (8x4 visible).
// Three instances: base (565, RD_LAT=1), lat (888, RD_LAT=3), win (window).
module tb_vga_stream_disp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clr_err = 1'b0;
  logic empty_a = 1'b0;

  int tests = 0;
  int fails = 0;

  // base instance
  logic        rd_req_a, hs_a, vs_a, blank_a, sync_a, fs_a, done_a, uf_a;
  logic [15:0] q_a = '0;
  logic [7:0]  r_a, g_a, b_a;
  logic [10:0] px_a, py_a;
  // latency instance
  logic        rd_req_l, hs_l, vs_l, blank_l, sync_l, fs_l, done_l, uf_l;
  logic [23:0] q_l = '0, l1 = '0, l2 = '0;
  logic [7:0]  r_l, g_l, b_l;
  logic [10:0] px_l, py_l;
  // window instance
  logic        rd_req_w, hs_w, vs_w, blank_w, sync_w, fs_w, done_w, uf_w;
  logic [15:0] q_w = '0;
  logic [7:0]  r_w, g_w, b_w;
  logic [10:0] px_w, py_w;

  logic [15:0] tab565 [3] = '{16'hF800, 16'h07E0, 16'h001F};
  logic [23:0] exp888 [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
  int cnt_a = 0;

  vga_stream_disp #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .IMG_W(8), .IMG_H(4), .RD_LAT(1)) u_base (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .rd_req(rd_req_a), .rd_q(q_a), .rd_empty(empty_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank(blank_a), .vga_sync(sync_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .pos_x(px_a), .pos_y(py_a),
    .frame_start(fs_a), .vga_done(done_a), .underflow(uf_a));

  vga_stream_disp #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .PIX_FMT(1), .IN_W(24),
                    .IMG_W(8), .IMG_H(4), .RD_LAT(3)) u_lat (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .rd_req(rd_req_l), .rd_q(q_l), .rd_empty(1'b0),
    .vga_hs(hs_l), .vga_vs(vs_l), .vga_blank(blank_l), .vga_sync(sync_l),
    .vga_r(r_l), .vga_g(g_l), .vga_b(b_l), .pos_x(px_l), .pos_y(py_l),
    .frame_start(fs_l), .vga_done(done_l), .underflow(uf_l));

  vga_stream_disp #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .IMG_X(2), .IMG_Y(1), .IMG_W(4), .IMG_H(2), .RD_LAT(1),
                    .BORDER_RGB(24'h203040)) u_win (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .rd_req(rd_req_w), .rd_q(q_w), .rd_empty(1'b0),
    .vga_hs(hs_w), .vga_vs(vs_w), .vga_blank(blank_w), .vga_sync(sync_w),
    .vga_r(r_w), .vga_g(g_w), .vga_b(b_w), .pos_x(px_w), .pos_y(py_w),
    .frame_start(fs_w), .vga_done(done_w), .underflow(uf_w));

  // FIFO models: data valid RD_LAT clocks after the read strobe; zero when
  // no read was issued so that misaligned sampling is visible.
  always @(posedge clk) begin
    if (rst) cnt_a <= 0;
    else if (rd_req_a) begin
      q_a   <= tab565[cnt_a];
      cnt_a <= (cnt_a == 2) ? 0 : cnt_a + 1;
    end
    l1  <= rd_req_l ? 24'h123456 : 24'h000000;
    l2  <= l1;
    q_l <= l2;
    q_w <= rd_req_w ? 16'hFFFF : 16'h0000;
  end

  task automatic wait_fs(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && fs_a) || (which == 1 && fs_l) || (which == 2 && fs_w)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      tests++;
      if (rd_req_a !== 1'b0) begin
        fails++; $display("FAIL reset_rd_req cycle %0d: got %b want 0", c, rd_req_a);
      end
      tests++;
      if ({blank_a, hs_a, vs_a, sync_a, fs_a, done_a, uf_a, r_a, g_a, b_a} !== {7'b0110000, 24'h0}) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: blank=%b hs=%b vs=%b sync=%b fs=%b done=%b uf=%b rgb=%h",
                 c, blank_a, hs_a, vs_a, sync_a, fs_a, done_a, uf_a, {r_a, g_a, b_a});
      end
    end
  endtask

  task automatic test_steady();
    bit ok;
    int rk = 0, reads0 = 0, reads1 = 0, dones = 0;
    bit hv [3] = '{0, 0, 0};
    int hk [3] = '{0, 0, 0};
    enable = 1'b1;
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL steady_start: frame_start not seen"); end
    for (int c = 0; c < 196; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = rd_req_a;
      hk[2] = hk[1]; hk[1] = hk[0]; hk[0] = rk;
      if (rd_req_a) begin
        rk++;
        if (c < 98) reads0++; else reads1++;
      end
      tests++;
      if (blank_a !== hv[2]) begin
        fails++; $display("FAIL steady_blank cycle %0d: got %b want %b", c, blank_a, hv[2]);
      end
      if (hv[2]) begin
        tests++;
        if ({r_a, g_a, b_a} !== exp888[hk[2] % 3]) begin
          fails++; $display("FAIL steady_rgb cycle %0d: got %h want %h", c, {r_a, g_a, b_a}, exp888[hk[2] % 3]);
        end
      end
      if (done_a) begin
        dones++;
        tests++;
        if (c % 98 != 51) begin fails++; $display("FAIL steady_done_pos: got cycle %0d want 51 mod 98", c); end
      end
      if (c == 11 || c == 12) begin
        tests++;
        if (hs_a !== (c == 11)) begin fails++; $display("FAIL steady_hs cycle %0d: got %b", c, hs_a); end
      end
      if (c == 98) begin
        tests++;
        if (fs_a !== 1'b1) begin fails++; $display("FAIL steady_fs2: got %b want 1", fs_a); end
      end
    end
    tests++;
    if (reads0 != 32) begin fails++; $display("FAIL steady_reads0: got %0d want 32", reads0); end
    tests++;
    if (reads1 != 32) begin fails++; $display("FAIL steady_reads1: got %0d want 32", reads1); end
    tests++;
    if (dones != 2) begin fails++; $display("FAIL steady_done_count: got %0d want 2", dones); end
  endtask

  task automatic test_latency();
    bit ok;
    int reads = 0;
    bit hv [5] = '{0, 0, 0, 0, 0};
    wait_fs(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL lat_start: frame_start not seen"); end
    for (int c = 0; c < 98; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      for (int i = 4; i > 0; i--) hv[i] = hv[i-1];
      hv[0] = rd_req_l;
      if (rd_req_l) reads++;
      tests++;
      if (blank_l !== hv[4]) begin
        fails++; $display("FAIL lat_blank cycle %0d: got %b want %b", c, blank_l, hv[4]);
      end
      if (hv[4]) begin
        tests++;
        if ({r_l, g_l, b_l} !== 24'h123456) begin
          fails++; $display("FAIL lat_rgb cycle %0d: got %h want 123456", c, {r_l, g_l, b_l});
        end
      end
      if (c == 13 || c == 16) begin
        tests++;
        if (hs_l !== 1'b1) begin fails++; $display("FAIL lat_hs_idle cycle %0d: got %b want 1", c, hs_l); end
      end
      if (c == 14 || c == 15) begin
        tests++;
        if (hs_l !== 1'b0) begin fails++; $display("FAIL lat_hs_act cycle %0d: got %b want 0", c, hs_l); end
      end
      if (c == 73 || c == 88) begin
        tests++;
        if (vs_l !== 1'b1) begin fails++; $display("FAIL lat_vs_idle cycle %0d: got %b want 1", c, vs_l); end
      end
      if (c == 74 || c == 87) begin
        tests++;
        if (vs_l !== 1'b0) begin fails++; $display("FAIL lat_vs_act cycle %0d: got %b want 0", c, vs_l); end
      end
    end
    tests++;
    if (reads != 32) begin fails++; $display("FAIL lat_reads: got %0d want 32", reads); end
  endtask

  task automatic test_window();
    bit ok;
    int reads = 0, border = 0, img = 0, dones = 0, done_at = -1;
    wait_fs(2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL win_start: frame_start not seen"); end
    for (int c = 0; c < 98; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      if (rd_req_w) reads++;
      if (blank_w && {r_w, g_w, b_w} === 24'h203040) border++;
      if (blank_w && {r_w, g_w, b_w} === 24'hFFFFFF) img++;
      if (done_w) begin dones++; done_at = c; end
    end
    tests++;
    if (reads != 8) begin fails++; $display("FAIL win_reads: got %0d want 8", reads); end
    tests++;
    if (border != 24) begin fails++; $display("FAIL win_border: got %0d want 24", border); end
    tests++;
    if (img != 8) begin fails++; $display("FAIL win_pixels: got %0d want 8", img); end
    tests++;
    if (dones != 1 || done_at != 35) begin
      fails++; $display("FAIL win_done: got count %0d at %0d want 1 at 35", dones, done_at);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL uf_start: frame_start not seen"); end
    for (int c = 0; c < 50; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      empty_a = (c >= 16 && c <= 18) || (c == 44);
      clr_err = (c == 40) || (c == 44);
      #1;
      if ((c >= 16 && c <= 18) || c == 44) begin
        tests++;
        if (rd_req_a !== 1'b0) begin fails++; $display("FAIL uf_no_read cycle %0d: got %b want 0", c, rd_req_a); end
      end
      if (c >= 18 && c <= 20) begin
        tests++;
        if ({blank_a, r_a, g_a, b_a} !== {1'b1, 24'hFF00FF}) begin
          fails++; $display("FAIL uf_colour cycle %0d: blank=%b rgb=%h want 1/ff00ff", c, blank_a, {r_a, g_a, b_a});
        end
      end
      if (c == 16 || c == 41) begin
        tests++;
        if (uf_a !== 1'b0) begin fails++; $display("FAIL uf_flag_clear cycle %0d: got %b want 0", c, uf_a); end
      end
      if (c == 17 || c == 39 || c == 45) begin
        tests++;
        if (uf_a !== 1'b1) begin fails++; $display("FAIL uf_flag_set cycle %0d: got %b want 1", c, uf_a); end
      end
    end
    empty_a = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic test_run_control();
    bit ok;
    int reads0 = 0, reads1 = 0, reads_idle = 0;
    // drop enable mid-frame: frame completes, then idle
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rc_start: frame_start not seen"); end
    for (int c = 0; c < 130; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 20) enable = 1'b0;
      #1;
      if (rd_req_a) begin if (c < 98) reads0++; else reads_idle++; end
      if (c == 98) begin
        tests++;
        if (fs_a !== 1'b0) begin fails++; $display("FAIL rc_no_restart: fs got %b want 0", fs_a); end
      end
      if (c == 110) begin
        tests++;
        if ({blank_a, hs_a, vs_a, r_a, g_a, b_a} !== {3'b011, 24'h0}) begin
          fails++; $display("FAIL rc_idle: blank=%b hs=%b vs=%b rgb=%h", blank_a, hs_a, vs_a, {r_a, g_a, b_a});
        end
      end
    end
    tests++;
    if (reads0 != 32) begin fails++; $display("FAIL rc_drain_reads: got %0d want 32", reads0); end
    tests++;
    if (reads_idle != 0) begin fails++; $display("FAIL rc_idle_reads: got %0d want 0", reads_idle); end

    // drop and re-raise enable within a frame: no gap between frames
    enable = 1'b1;
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rc_restart: frame_start not seen"); end
    reads0 = 0;
    for (int c = 0; c < 196; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 20) enable = 1'b0;
      if (c == 50) enable = 1'b1;
      #1;
      if (rd_req_a) begin if (c < 98) reads0++; else reads1++; end
      if (c == 98) begin
        tests++;
        if (fs_a !== 1'b1) begin fails++; $display("FAIL rc_continuous: fs got %b want 1", fs_a); end
      end
    end
    tests++;
    if (reads0 != 32 || reads1 != 32) begin
      fails++; $display("FAIL rc_cont_reads: got %0d/%0d want 32/32", reads0, reads1);
    end

    // reset mid-line: idle outputs on the next clock
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rc_rst_start: frame_start not seen"); end
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      empty_a = (c == 2);
      if (c == 5) begin rst = 1'b1; enable = 1'b0; end
      if (c == 6) rst = 1'b0;
      #1;
      if (c == 4) begin
        tests++;
        if (uf_a !== 1'b1 || blank_a !== 1'b1) begin
          fails++; $display("FAIL rc_pre_rst: uf=%b blank=%b want 1/1", uf_a, blank_a);
        end
      end
      if (c == 6 || c == 8) begin
        tests++;
        if ({rd_req_a, blank_a, hs_a, vs_a, fs_a, done_a, uf_a, r_a, g_a, b_a} !== {7'b0011000, 24'h0}) begin
          fails++;
          $display("FAIL rc_post_rst cycle %0d: rd=%b blank=%b hs=%b vs=%b fs=%b done=%b uf=%b rgb=%h",
                   c, rd_req_a, blank_a, hs_a, vs_a, fs_a, done_a, uf_a, {r_a, g_a, b_a});
        end
      end
    end
    empty_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_latency();
    test_window();
    test_underflow();
    test_run_control();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
